cv32e40p_register_file_ctx: RTL and testbench
=============================================

Name: cv32e40p_register_file_ctx

Overview:
- Flip-flop integer register file, generalised to NUM_READ read ports and NUM_WRITE write ports.
- Optional write-to-read bypass.
- Built-in context save/restore engine: streams x1..x(N-1) out or in over valid/ready handshakes for interrupt/context-switch support.
- Sits in the ID stage in place of the fixed 3R/2W file; the controller drives the context engine and stalls the pipeline on ctx_busy_o.

Parameters:
- ADDR_WIDTH, 5, register address width; NUM_WORDS = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register width.
- NUM_READ, 3, number of combinational read ports (1..4).
- NUM_WRITE, 2, number of write ports (1..3).
- BYPASS, 0, 1 = a read of a register being written this cycle returns the write data.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- raddr_i  in  NUM_READ*ADDR_WIDTH  read addresses; port k = slice k
- rdata_o  out  NUM_READ*DATA_WIDTH  read data; port k = slice k
- waddr_i  in  NUM_WRITE*ADDR_WIDTH  write addresses
- wdata_i  in  NUM_WRITE*DATA_WIDTH  write data
- we_i  in  NUM_WRITE  write enables
- ctx_save_req_i  in  1  start a save (sampled in IDLE only)
- ctx_restore_req_i  in  1  start a restore (sampled in IDLE only)
- ctx_busy_o  out  1  engine active
- ctx_done_o  out  1  one-cycle completion pulse
- ctx_out_valid_o  out  1  save stream valid
- ctx_out_ready_i  in  1  save stream ready
- ctx_out_data_o  out  DATA_WIDTH  save stream data
- ctx_in_valid_i  in  1  restore stream valid
- ctx_in_ready_o  out  1  restore stream ready
- ctx_in_data_i  in  DATA_WIDTH  restore stream data

Behaviour:
- Reset (async, rst=1):
  - All registers reset to 0; FSM to IDLE; index counter to 1.
  - ctx_busy_o, ctx_done_o, ctx_out_valid_o and ctx_in_ready_o reset to 0; ctx_out_data_o reads 0.
  - A reset mid-save or mid-restore aborts immediately: no done pulse, partial restore discarded.
- Register 0 always reads 0; writes to address 0 from any source are dropped.
- Reads are combinational: rdata_o[k] = mem[raddr_i[k]].
- BYPASS=1: if any write port with we_i=1 targets raddr_i[k] (non-zero), rdata_o[k] returns that port's wdata, using the highest-priority matching port. Restore-engine writes are never bypassed.
- Writes take effect at the clock edge and are visible the next cycle.
- Write priority: when several write ports hit the same address, the highest port index wins.
- ctx_busy_o = (state != IDLE). While busy, we_i is ignored for all ports; reads remain served.
- FSM states: IDLE, SAVE, RESTORE, DONE.
  - IDLE -> SAVE on ctx_save_req_i, with idx=1. Save has priority if both requests are asserted.
  - IDLE -> RESTORE on ctx_restore_req_i, with idx=1.
  - SAVE: ctx_out_valid_o=1 and ctx_out_data_o=mem[idx]. On valid&&ready, idx increments. A transfer at idx=NUM_WORDS-1 moves the FSM to DONE.
  - SAVE with ready low: data held stable (registers are frozen), valid stays 1.
  - RESTORE: ctx_in_ready_o=1. On valid&&ready, mem[idx] <= ctx_in_data_i and idx increments. A transfer at idx=NUM_WORDS-1 moves the FSM to DONE.
  - DONE: ctx_done_o=1 for exactly one cycle; next state IDLE.
- Requests asserted outside IDLE (including during DONE) are ignored, not queued.
- Timing with continuous handshakes: request at cycle 0 gives busy in cycles 1..NUM_WORDS (32 for the default), done pulse in cycle 32, and normal writes accepted again from cycle 33.
- Stream order is always ascending, x1 first; x0 is never transferred.

Test Plan:
- Reset then write x5=0xDEADBEEF via port 0 -> all read ports return 0xDEADBEEF from the next cycle; raddr=0 returns 0 after a write of 0x1234 to x0.
- Ports 0 and 1 both write x7 (0x11, 0x22) in the same cycle -> x7=0x22. With BYPASS=1 and raddr_i[0]=7, rdata_o[0] returns 0x22 in the same cycle.
- Load xi=i*3, then save with ready always high -> 31 beats 3,6,...,93 in cycles 1..31; ctx_done_o pulses in cycle 32; a we_i write issued in cycle 10 is dropped.
- Save with ready toggling 1,0,1,0 -> each beat is held stable while ready=0; exactly 31 transfers in total; done asserts only after the last transfer.
- Restore streaming 0x100+i with valid gaps -> afterwards xi=0x100+i for i=1..31 and x0=0; ctx_in_ready_o=0 after DONE.
- Assert save and restore together -> save runs. Assert rst during beat 12 of a restore -> all registers 0, busy=0, no done pulse.

Source files
------------

// File: rtl/cv32e40p_register_file_ctx.sv
// Flip-flop integer register file with NUM_READ/NUM_WRITE ports, optional write bypass,
// and a context engine that streams x1..x(N-1) out (save) or in (restore).
module cv32e40p_register_file_ctx #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ   = 3,
  parameter int NUM_WRITE  = 2,
  parameter int BYPASS     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   raddr_i,
  output logic [NUM_READ*DATA_WIDTH-1:0]   rdata_o,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  waddr_i,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]  wdata_i,
  input  logic [NUM_WRITE-1:0]             we_i,
  input  logic                             ctx_save_req_i,
  input  logic                             ctx_restore_req_i,
  output logic                             ctx_busy_o,
  output logic                             ctx_done_o,
  output logic                             ctx_out_valid_o,
  input  logic                             ctx_out_ready_i,
  output logic [DATA_WIDTH-1:0]            ctx_out_data_o,
  input  logic                             ctx_in_valid_i,
  output logic                             ctx_in_ready_o,
  input  logic [DATA_WIDTH-1:0]            ctx_in_data_i,
  output logic [1:0]                       dbg_state_o
);

  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_RESTORE, ST_DONE} state_t;

  // Stream handshakes: a beat transfers on the rising edge where valid && ready are both high.
  state_t                  r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_idx, w_idx_nxt;
  logic [DATA_WIDTH-1:0]   r_mem [NUM_WORDS];
  logic                    w_in_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= FIRST_IDX;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_in_fire       = 1'b0;
    ctx_busy_o      = (r_state != ST_IDLE);
    ctx_done_o      = 1'b0;
    ctx_out_valid_o = 1'b0;
    ctx_out_data_o  = '0;
    ctx_in_ready_o  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ctx_save_req_i) begin
          w_state_nxt = ST_SAVE;
          w_idx_nxt   = FIRST_IDX;
        end else if (ctx_restore_req_i) begin
          w_state_nxt = ST_RESTORE;
          w_idx_nxt   = FIRST_IDX;
        end
      end
      ST_SAVE: begin
        ctx_out_valid_o = 1'b1;
        ctx_out_data_o  = r_mem[r_idx];
        if (ctx_out_ready_i) begin
          w_idx_nxt = r_idx + 1'b1;
          if (r_idx == LAST_IDX) w_state_nxt = ST_DONE;
        end
      end
      ST_RESTORE: begin
        ctx_in_ready_o = 1'b1;
        if (ctx_in_valid_i) begin
          w_in_fire = 1'b1;
          w_idx_nxt = r_idx + 1'b1;
          if (r_idx == LAST_IDX) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        ctx_done_o  = 1'b1;
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = FIRST_IDX;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign dbg_state_o = r_state;

  // Port writes are only honoured in IDLE; later ports overwrite earlier ones on an address clash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) r_mem[i] <= '0;
    end else if (r_state == ST_IDLE) begin
      for (int p = 0; p < NUM_WRITE; p++) begin
        if (we_i[p] && (waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH] != '0))
          r_mem[waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (w_in_fire) begin
      r_mem[r_idx] <= ctx_in_data_i;
    end
  end

  // x0 is never written, so it always reads its reset value of zero.
  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]];
      if ((BYPASS != 0) && (r_state == ST_IDLE) && (raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
        for (int p = 0; p < NUM_WRITE; p++) begin
          if (we_i[p] && (waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]))
            rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_register_file_ctx.sv
// Directed + randomized bench for cv32e40p_register_file_ctx (BYPASS=1) against an array reference model.
module tb_cv32e40p_register_file_ctx;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;
  localparam int NW = 2;

  logic               clk;
  logic               rst;
  logic [NR*AW-1:0]   raddr;
  logic [NR*DW-1:0]   rdata;
  logic [NW*AW-1:0]   waddr;
  logic [NW*DW-1:0]   wdata;
  logic [NW-1:0]      we;
  logic               save_req, restore_req;
  logic               busy, done;
  logic               out_valid, out_ready;
  logic [DW-1:0]      out_data;
  logic               in_valid, in_ready;
  logic [DW-1:0]      in_data;
  logic [1:0]         dbg_state;

  logic [DW-1:0]      model [32];
  int                 n_checks;
  int                 n_fail;

  cv32e40p_register_file_ctx #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst),
    .raddr_i(raddr), .rdata_o(rdata),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .ctx_save_req_i(save_req), .ctx_restore_req_i(restore_req),
    .ctx_busy_o(busy), .ctx_done_o(done),
    .ctx_out_valid_o(out_valid), .ctx_out_ready_i(out_ready), .ctx_out_data_o(out_data),
    .ctx_in_valid_i(in_valid), .ctx_in_ready_o(in_ready), .ctx_in_data_i(in_data),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
    we[p] = 1'b1;
    waddr[p*AW +: AW] = 5'(a);
    wdata[p*DW +: DW] = d;
  endtask

  task automatic set_rd(input int k, input int a);
    raddr[k*AW +: AW] = 5'(a);
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return rdata[k*DW +: DW];
  endfunction

  task automatic check_all_regs(input string tag);
    we = '0;
    for (int r = 0; r < 32; r++) begin
      for (int k = 0; k < NR; k++) set_rd(k, (r + k) % 32);
      #1;
      for (int k = 0; k < NR; k++) check(tag, rd(k), model[(r + k) % 32]);
    end
  endtask

  initial begin
    int xfers, kbeat, ra[NR];
    bit seen_done;
    logic [DW-1:0] exp_d;
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    raddr = '0; waddr = '0; wdata = '0; we = '0;
    save_req = 0; restore_req = 0; out_ready = 0; in_valid = 0; in_data = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    for (int k = 0; k < NR; k++) set_rd(k, $urandom_range(1, 31));
    #1;
    for (int k = 0; k < NR; k++) check("rst_rdata", rd(k), 0);
    rst = 1'b0;
    tick();

    // Basic write/read, x0 hardwired
    set_wr(0, 5, 32'hDEADBEEF);
    tick();
    we = '0;
    model[5] = 32'hDEADBEEF;
    for (int k = 0; k < NR; k++) set_rd(k, 5);
    #1;
    for (int k = 0; k < NR; k++) check("x5_read", rd(k), 32'hDEADBEEF);
    set_wr(0, 0, 32'h1234);
    tick();
    we = '0;
    set_rd(0, 0);
    #1;
    check("x0_zero", rd(0), 0);

    // Write-port priority and bypass
    set_wr(0, 7, 32'h11);
    set_wr(1, 7, 32'h22);
    set_rd(0, 7);
    #1;
    check("bypass_prio", rd(0), 32'h22);
    tick();
    we = '0;
    model[7] = 32'h22;
    for (int k = 0; k < NR; k++) set_rd(k, 7);
    #1;
    for (int k = 0; k < NR; k++) check("x7_prio", rd(k), 32'h22);

    // Random writes and reads with in-cycle bypass expectations
    for (int t = 0; t < 40; t++) begin
      for (int p = 0; p < NW; p++) begin
        we[p] = 1'($urandom_range(0, 1));
        waddr[p*AW +: AW] = 5'($urandom_range(0, 31));
        wdata[p*DW +: DW] = $urandom;
      end
      for (int k = 0; k < NR; k++) begin
        ra[k] = ($urandom_range(0, 1) == 1) ? int'(waddr[$urandom_range(0, NW-1)*AW +: AW])
                                             : int'($urandom_range(0, 31));
        set_rd(k, ra[k]);
      end
      #1;
      for (int k = 0; k < NR; k++) begin
        exp_d = model[ra[k]];
        for (int p = 0; p < NW; p++)
          if (ra[k] != 0 && we[p] && int'(waddr[p*AW +: AW]) == ra[k]) exp_d = wdata[p*DW +: DW];
        check("rand_read", rd(k), exp_d);
      end
      tick();
      for (int p = 0; p < NW; p++)
        if (we[p] && waddr[p*AW +: AW] != 0) model[waddr[p*AW +: AW]] = wdata[p*DW +: DW];
    end
    we = '0;

    // Load xi = i*3
    for (int i = 1; i < 32; i++) begin
      we = '0;
      set_wr(0, i, 32'(i * 3));
      tick();
      model[i] = 32'(i * 3);
    end
    we = '0;
    check_all_regs("load_x3");

    // Save with ready always high; write in cycle 10 must be dropped
    out_ready = 1;
    save_req = 1;
    #1;
    check("save_c0_busy", busy, 0);
    tick();
    save_req = 0;
    for (int c = 1; c <= 32; c++) begin
      we = '0;
      if (c == 10) set_wr(0, 4, 32'hFFFF_FFFF);
      #1;
      check("save_busy", busy, 1);
      if (c <= 31) begin
        check("save_valid", out_valid, 1);
        check("save_data", out_data, model[c]);
        check("save_done_early", done, 0);
      end else begin
        check("save_valid_end", out_valid, 0);
        check("save_done", done, 1);
      end
      tick();
    end
    we = '0;
    set_wr(0, 9, 32'h55);
    #1;
    check("save_c33_busy", busy, 0);
    check("save_c33_done", done, 0);
    tick();
    we = '0;
    model[9] = 32'h55;
    check_all_regs("after_save");

    // Save with toggling ready; restore request during DONE is ignored
    save_req = 1;
    out_ready = 0;
    tick();
    save_req = 0;
    xfers = 0;
    seen_done = 0;
    for (int cyc = 1; cyc < 120; cyc++) begin
      out_ready = cyc[0];
      restore_req = (xfers == 31);
      #1;
      if (done) begin
        seen_done = 1;
        check("toggle_xfers_at_done", 32'(xfers), 31);
        check("toggle_valid_at_done", out_valid, 0);
        tick();
        break;
      end
      check("toggle_valid", out_valid, 1);
      check("toggle_data", out_data, model[xfers + 1]);
      if (out_valid && out_ready) xfers++;
      tick();
    end
    restore_req = 0;
    out_ready = 0;
    check("toggle_done_seen", seen_done, 1);
    #1;
    check("done_req_ignored", busy, 0);
    check("done_req_no_ready", in_ready, 0);

    // Restore with random valid gaps
    restore_req = 1;
    tick();
    restore_req = 0;
    kbeat = 1;
    seen_done = 0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 32'h100 + 32'(kbeat);
      #1;
      if (kbeat > 31) begin
        seen_done = 1;
        check("rest_done", done, 1);
        check("rest_ready_done", in_ready, 0);
        tick();
        break;
      end
      check("rest_ready", in_ready, 1);
      check("rest_done_early", done, 0);
      if (in_valid) begin
        model[kbeat] = in_data;
        kbeat++;
      end
      tick();
    end
    in_valid = 0;
    check("rest_done_seen", seen_done, 1);
    #1;
    check("rest_idle_ready", in_ready, 0);
    check("rest_idle_busy", busy, 0);
    check_all_regs("after_restore");

    // Simultaneous requests: save wins
    save_req = 1;
    restore_req = 1;
    out_ready = 0;
    tick();
    save_req = 0;
    restore_req = 0;
    #1;
    check("both_save_valid", out_valid, 1);
    check("both_no_in_ready", in_ready, 0);
    check("both_data", out_data, model[1]);
    out_ready = 1;
    seen_done = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (done) begin
        seen_done = 1;
        tick();
        break;
      end
      tick();
    end
    out_ready = 0;
    check("both_done_seen", seen_done, 1);

    // Reset during beat 12 of a restore
    restore_req = 1;
    tick();
    restore_req = 0;
    in_valid = 1;
    for (int k = 1; k < 12; k++) begin
      in_data = 32'hA00 + 32'(k);
      tick();
    end
    in_data = 32'hA00 + 32'd12;
    #1;
    check("pre_rst_busy", busy, 1);
    rst = 1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_done", done, 0);
    tick();
    rst = 0;
    in_valid = 0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("postrst_no_done", done, 0);
      tick();
    end
    check_all_regs("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
